// File: rtl/alu_sel_pkg.sv
// Shared types and helpers for the ALU result selector pipeline.
package alu_sel_pkg;

    localparam int FLAG_W = 2;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} sel_state_t;

    function automatic int sel_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/alu_result_sel_pipe_if.sv
// Handshake bundle between the ALU result sources, the selector and the writeback stage.
interface alu_result_sel_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 9
);
    localparam int SEL_W = alu_sel_pkg::sel_w(NUM_IN);

    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN*WIDTH-1:0] values;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_sel_err;
    logic                    out_zero;
    logic                    out_neg;

    modport slave (
        input  in_valid, sel, values, out_ready,
        output in_ready, out_valid, out_data, out_sel_err, out_zero, out_neg
    );

    modport master (
        output in_valid, sel, values, out_ready,
        input  in_ready, out_valid, out_data, out_sel_err, out_zero, out_neg
    );
endinterface

// File: rtl/alu_sel_skid.sv
// Two-entry skid buffer: output register plus one stall entry, with registered in_ready.
//
//   state | meaning
//   EMPTY | nothing held, output invalid
//   ONE   | output register holds a result
//   TWO   | output register and skid entry both hold results, input stalled
module alu_sel_skid
    import alu_sel_pkg::*;
#(
    parameter int PAY_W = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [PAY_W-1:0] in_payload_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [PAY_W-1:0] out_payload_o
);

    sel_state_t       state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [PAY_W-1:0] out_q;
    logic [PAY_W-1:0] skid_q;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer  = in_valid_i & in_ready_q;
    assign out_xfer = out_valid_q & out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (in_xfer) begin
                        out_q       <= in_payload_i;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_q <= in_payload_i;
                    end else if (in_xfer) begin
                        skid_q     <= in_payload_i;
                        in_ready_q <= 1'b0;
                        state_q    <= TWO;
                    end else if (out_xfer) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Registered ready, forced low combinationally only while reset is held.
    assign in_ready_o    = in_ready_q & ~rst;
    assign out_valid_o   = out_valid_q;
    assign out_payload_o = out_q;

endmodule

// File: rtl/alu_result_sel_pipe.sv
// N-way ALU result selector feeding a 2-entry skid buffer toward writeback.
// Define ALU_SEL_FLAGS_EN to compute and carry zero/negative flags with each result.
module alu_result_sel_pipe
    import alu_sel_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_result_sel_pipe_if.slave  bus
);

    localparam int SEL_W = sel_w(NUM_IN);

    logic [WIDTH-1:0] sel_data;
    logic             sel_hit;
    logic             sel_err;

    // Illegal selects fall back to values[0] and are flagged.
    always_comb begin
        sel_data = bus.values[0 +: WIDTH];
        sel_hit  = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                sel_data = bus.values[i*WIDTH +: WIDTH];
                sel_hit  = 1'b1;
            end
        end
        sel_err = ~sel_hit;
    end

`ifdef ALU_SEL_FLAGS_EN
    localparam int PAY_W = 1 + FLAG_W + WIDTH;

    logic [FLAG_W-1:0] sel_flags;
    logic [FLAG_W-1:0] out_flags;
    logic [PAY_W-1:0]  pay_in;
    logic [PAY_W-1:0]  pay_out;

    assign sel_flags = {sel_data[WIDTH-1], (sel_data == '0)};
    assign pay_in    = {sel_err, sel_flags, sel_data};

    assign {bus.out_sel_err, out_flags, bus.out_data} = pay_out;
    assign bus.out_neg  = out_flags[1];
    assign bus.out_zero = out_flags[0];
`else
    localparam int PAY_W = 1 + WIDTH;

    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_out;

    assign pay_in = {sel_err, sel_data};

    assign {bus.out_sel_err, bus.out_data} = pay_out;
    assign bus.out_neg  = 1'b0;
    assign bus.out_zero = 1'b0;
`endif

    alu_sel_skid #(
        .PAY_W (PAY_W)
    ) u_skid (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (bus.in_valid),
        .in_ready_o    (bus.in_ready),
        .in_payload_i  (pay_in),
        .out_valid_o   (bus.out_valid),
        .out_ready_i   (bus.out_ready),
        .out_payload_o (pay_out)
    );

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Randomised self-checking bench: a FIFO-of-capacity-2 reference model of the selector pipeline.
module tb_alu_result_sel_pipe;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 9;
    localparam int VW     = NUM_IN * WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_result_sel_pipe_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) bus ();

    alu_result_sel_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Each entry: {sel_err, neg, zero, data}
    logic [34:0] q[$];
    logic        rst_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] model(input logic [3:0] s, input logic [VW-1:0] vals);
        logic [31:0] d;
        logic        err;
        logic        z;
        logic        n;
        err = (int'(s) >= NUM_IN);
        d   = err ? vals[31:0] : vals[int'(s)*WIDTH +: WIDTH];
`ifdef ALU_SEL_FLAGS_EN
        z = (d == 32'd0);
        n = d[31];
`else
        z = 1'b0;
        n = 1'b0;
`endif
        return {err, n, z, d};
    endfunction

    function automatic logic [VW-1:0] rand_vals();
        logic [VW-1:0] v;
        for (int i = 0; i < NUM_IN; i++) begin
            case ($urandom_range(0, 7))
                0:       v[i*WIDTH +: WIDTH] = 32'd0;
                1:       v[i*WIDTH +: WIDTH] = 32'h8000_0000 | $urandom_range(0, 15);
                default: v[i*WIDTH +: WIDTH] = $urandom;
            endcase
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] put(input logic [VW-1:0] v, input int idx, input logic [31:0] w);
        logic [VW-1:0] r;
        r = v;
        r[idx*WIDTH +: WIDTH] = w;
        return r;
    endfunction

    task automatic step(input logic iv, input logic [3:0] s, input logic [VW-1:0] vals,
                        input logic ordy, input logic r);
        logic [34:0] head;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.sel       = s;
        bus.values    = vals;
        bus.out_ready = ordy;
        rst           = r;
        #1;
        if (r) begin
            q.delete();
            check_eq("in_ready_rst", {63'd0, bus.in_ready}, 64'd0);
            if (rst_prev) begin
                check_eq("out_valid_rst", {63'd0, bus.out_valid}, 64'd0);
                check_eq("out_data_rst", {32'd0, bus.out_data}, 64'd0);
                check_eq("flags_rst", {61'd0, bus.out_sel_err, bus.out_neg, bus.out_zero}, 64'd0);
            end
        end else begin
            check_eq("in_ready", {63'd0, bus.in_ready}, {63'd0, (!rst_prev && q.size() < 2)});
            check_eq("out_valid", {63'd0, bus.out_valid}, {63'd0, (q.size() != 0)});
            if (bus.out_valid === 1'b1 && q.size() != 0) begin
                head = q[0];
                check_eq("out_data", {32'd0, bus.out_data}, {32'd0, head[31:0]});
                check_eq("out_sel_err", {63'd0, bus.out_sel_err}, {63'd0, head[34]});
                check_eq("out_flags", {62'd0, bus.out_neg, bus.out_zero}, {62'd0, head[33:32]});
                if (ordy) void'(q.pop_front());
            end
            if (iv && bus.in_ready === 1'b1) q.push_back(model(s, vals));
        end
        rst_prev = r;
    endtask

    initial begin
        logic [VW-1:0] v;
        bus.in_valid  = 1'b0;
        bus.sel       = '0;
        bus.values    = '0;
        bus.out_ready = 1'b0;

        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);

        // single select, then illegal select
        v = put(rand_vals(), 3, 32'h0000_00A5);
        step(1, 4'd3, v, 1, 0);
        v = put(rand_vals(), 0, 32'hDEAD_BEEF);
        step(1, 4'd12, v, 1, 0);
        step(0, 0, v, 1, 0);
        step(0, 0, v, 1, 0);

        // backpressure: fill both entries, then drain
        step(1, 4'd1, put(rand_vals(), 1, 32'd11), 0, 0);
        step(1, 4'd2, put(rand_vals(), 2, 32'd22), 0, 0);
        step(0, 0, v, 0, 0);
        step(0, 0, v, 1, 0);
        step(0, 0, v, 1, 0);
        step(0, 0, v, 1, 0);

        // streaming sel 0..8 back to back
        for (int i = 0; i < NUM_IN; i++) step(1, 4'(i), rand_vals(), 1, 0);
        step(0, 0, v, 1, 0);
        step(0, 0, v, 1, 0);

        // reset while full; the skid entry must not appear afterwards
        step(1, 4'd4, rand_vals(), 0, 0);
        step(1, 4'd5, rand_vals(), 0, 0);
        step(0, 0, v, 0, 1);
        step(0, 0, v, 1, 1);
        step(0, 0, v, 1, 0);
        step(0, 0, v, 1, 0);
        step(0, 0, v, 1, 0);

        // flag patterns
        step(1, 4'd6, put(rand_vals(), 6, 32'd0), 1, 0);
        step(1, 4'd7, put(rand_vals(), 7, 32'h8000_0001), 1, 0);
        step(0, 0, v, 1, 0);
        step(0, 0, v, 1, 0);

        // random traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), rand_vals(),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 249) == 0));
        end
        step(0, 0, v, 1, 0);
        step(0, 0, v, 1, 0);
        step(0, 0, v, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
